// File: rtl/pc_sequencer.sv
// pc_sequencer: FETCH/DECODE/EXEC/UPDATE instruction-cycle controller with a fetch-wait timeout.
// Define PC_SEQ_RAS_EN to build in the internal return-address stack; otherwise raOut passes raIn.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        memReady,
    input  logic [3:0]  opcode,
    input  logic [15:0] pcOut,
    input  logic [15:0] raIn,
    output logic [2:0]  pcSrc,
    output logic        pcWrite,
    output logic        memRead,
    output logic        irWrite,
    output logic [15:0] raOut,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  rasCount
);

    // state  | meaning
    // FETCH  | fetch request outstanding, counting wait cycles
    // DECODE | instruction register load
    // EXEC   | opcode capture and HALT check
    // UPDATE | PC write, stack push/pop
    // HALT   | terminal, left only by reset
    // FAULT  | terminal fetch timeout, left only by reset
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        UPDATE = 3'd3,
        HALT   = 3'd4,
        FAULT  = 3'd5
    } seqState;

    localparam logic [3:0] OP_RET    = 4'b0011;
    localparam logic [3:0] OP_CALL   = 4'b1000;
    localparam logic [3:0] OP_HALT   = 4'b1111;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    seqState    state;
    seqState    stateNext;
    logic [7:0] waitCnt;
    logic [7:0] waitCntNext;
    logic [3:0] opReg;
    logic [3:0] opRegNext;
    logic [2:0] pcSrcReg;
    logic [2:0] pcSrcNext;
    logic       memReadInt;
    logic       doPush;
    logic       doPop;

    function automatic logic [2:0] srcMap(input logic [3:0] op);
        case (op)
            4'b0000: return 3'b000;
            4'b0001: return 3'b001;
            4'b0010: return 3'b010;
            4'b0011: return 3'b011;
            4'b0100: return 3'b100;
            4'b0101: return 3'b101;
            4'b0110: return 3'b110;
            4'b0111: return 3'b111;
            4'b1000: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            waitCnt  <= '0;
            opReg    <= '0;
            pcSrcReg <= '0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            opReg    <= opRegNext;
            pcSrcReg <= pcSrcNext;
        end
    end

    // Every advancing branch is gated by !stall, so a stall freezes all state.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        opRegNext   = opReg;
        pcSrcNext   = pcSrcReg;
        memReadInt  = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        doPush      = 1'b0;
        doPop       = 1'b0;
        case (state)
            FETCH: begin
                memReadInt = 1'b1;
                if (!stall) begin
                    if (memReady) begin
                        stateNext   = DECODE;
                        waitCntNext = '0;
                    end else if (waitCnt == WAIT_LAST) begin
                        stateNext = FAULT;
                    end else begin
                        waitCntNext = waitCnt + 8'd1;
                    end
                end
            end
            DECODE: begin
                if (!stall) begin
                    irWrite   = 1'b1;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    opRegNext = opcode;
                    pcSrcNext = srcMap(opcode);
                    stateNext = (opcode == OP_HALT) ? HALT : UPDATE;
                end
            end
            UPDATE: begin
                if (!stall) begin
                    pcWrite   = 1'b1;
                    doPush    = (opReg == OP_CALL);
                    doPop     = (opReg == OP_RET);
                    pcSrcNext = 3'b000;
                    stateNext = FETCH;
                end
            end
            HALT, FAULT: begin
                stateNext = state;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign pcSrc   = pcSrcReg;
    assign memRead = memReadInt & ~reset;
    assign halted  = (state == HALT);
    assign fault   = (state == FAULT);

`ifdef PC_SEQ_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [3:0] RAS_FULL = 4'(RAS_DEPTH);

    logic [15:0]   rasMem [RAS_DEPTH];
    logic [PW-1:0] rasPtr;
    logic [PW-1:0] rasTop;
    logic [3:0]    rasCnt;
    logic          unusedRas;

    // rasPtr is the next write slot; a push when full overwrites the oldest entry.
    assign rasTop = rasPtr - PW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rasPtr <= '0;
            rasCnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                rasMem[i] <= '0;
            end
        end else if (doPush) begin
            rasMem[rasPtr] <= pcOut + 16'd1;
            rasPtr         <= rasPtr + PW'(1);
            if (rasCnt != RAS_FULL) begin
                rasCnt <= rasCnt + 4'd1;
            end
        end else if (doPop && (rasCnt != 4'd0)) begin
            rasPtr <= rasTop;
            rasCnt <= rasCnt - 4'd1;
        end
    end

    assign raOut     = (rasCnt == 4'd0) ? 16'h0000 : rasMem[rasTop];
    assign rasCount  = rasCnt;
    assign unusedRas = ^raIn;
`else
    logic unusedRas;

    assign raOut     = raIn;
    assign rasCount  = 4'd0;
    assign unusedRas = ^{pcOut, doPush, doPop, opReg};
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: FETCH wait-cycle limit before fault (1..255).
REQ-002 Parameter RAS_DEPTH, default 4: return-address stack entries (power of 2, 2..8).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  freeze sequencing while high.
REQ-006 memReady  input  1  instruction memory data valid.
REQ-007 opcode  input  4  instruction class from instruction register.
REQ-008 pcOut  input  16  current PC value.
REQ-009 raIn  input  16  return-address register value.
REQ-010 pcSrc  output  3  PC next-value select.
REQ-011 pcWrite  output  1  PC write enable.
REQ-012 memRead  output  1  instruction fetch request.
REQ-013 irWrite  output  1  instruction register load.
REQ-014 raOut  output  16  return address supplied to the PC mux.
REQ-015 halted  output  1  HALT state indicator.
REQ-016 fault  output  1  fetch-timeout indicator.
REQ-017 rasCount  output  4  stack occupancy.

Function
REQ-018 States: FETCH, DECODE, EXEC, UPDATE, HALT, FAULT; exactly one state active.
REQ-019 FETCH: memRead=1; memReady=1 -> DECODE, wait counter cleared; else counter+1; counter reaching MEM_TIMEOUT without memReady -> FAULT.
REQ-020 DECODE: irWrite=1 for exactly one cycle -> EXEC.
REQ-021 EXEC: one cycle, no outputs asserted -> UPDATE; opcode 1111 -> HALT instead.
REQ-022 UPDATE: pcWrite=1 for exactly one cycle, pcSrc from opcode -> FETCH.
REQ-023 pcSrc map: 0000 ALU->000; 0001 rel branch->001; 0010 jump->010; 0011 return->011; 0100 mem jump->100; 0101 scaled rel->101; 0110 cond abs->110; 0111 cond rel->111; 1000 call->010; other non-1111 codes->000.
REQ-024 Conditional opcodes (0110, 0111) still assert pcWrite; comparison gating lies in the PC datapath, not here.
REQ-025 pcSrc registered, held stable from EXEC through UPDATE; 000 in all other states.
REQ-026 Unstalled latency: 4 cycles per instruction when memReady is high on the first FETCH cycle.
REQ-027 stall=1 in FETCH/DECODE/EXEC/UPDATE: state, wait counter and stack frozen; pcWrite and irWrite forced 0; memRead held; stall beats memReady in the same cycle, and memReady is resampled after stall drops.
REQ-028 HALT and FAULT are terminal: all strobes 0, stall ignored, exited only by reset.
REQ-029 halted=1 only in HALT; fault=1 only in FAULT.

Reset
REQ-030 reset asserted at any time, including mid-instruction: state->FETCH, counter->0, stack emptied, rasCount=0.
REQ-031 Outputs during reset: pcSrc=000, pcWrite=0, irWrite=0, memRead=0, halted=0, fault=0, raOut=0 (RAS_EN) or raIn (no RAS_EN).
REQ-032 First cycle after reset release is FETCH, with memRead=1.

Configuration
REQ-033 Macro PC_SEQ_RAS_EN defined: internal RAS_DEPTH-entry return stack; call (1000) in UPDATE pushes pcOut+1; return (0011) in UPDATE pops; raOut = top entry, 0 when empty.
REQ-034 Push when full: wraps circularly, overwriting the oldest entry; rasCount stays RAS_DEPTH.
REQ-035 Pop when empty: no change; rasCount stays 0; raOut=0.
REQ-036 PC_SEQ_RAS_EN undefined: no stack logic; raOut=raIn combinationally; rasCount=0 constantly.

Verification
REQ-037 Reset release, memReady=1 permanently, opcode=0000 -> pcWrite pulses every 4th cycle, pcSrc=000, irWrite pulses one cycle before EXEC.
REQ-038 memReady held 0 with MEM_TIMEOUT=15 -> fault=1 after the 15th FETCH cycle; fault persists with memReady=1 until reset.
REQ-039 opcode=0110, then stall=1 for 3 cycles during UPDATE -> pcWrite=0 for 3 cycles, then a single pcWrite pulse with pcSrc=110.
REQ-040 RAS_EN: calls at pcOut=0x0010, 0x0020, then return -> raOut=0x0021, 0x0011 after pop, rasCount 2->1; 5 calls with depth 4 -> rasCount=4, oldest entry lost.
REQ-041 opcode=1111 -> halted=1 after EXEC, no further memRead; reset -> FETCH with halted=0.
REQ-042 reset asserted mid-DECODE with 2 stack entries -> all outputs at reset values immediately, rasCount=0.
